ds1302_write: RTL and testbench
===============================

DS1302_WRITE -- requirements
Module: ds1302_write

Interface
REQ-001 The block SHALL have parameter HALF_CYC, default 100, meaning clk cycles per SCLK half-period (500 kHz SCLK at 100 MHz).
REQ-002 The block SHALL have parameter CE_CYC, default 400, meaning clk cycles for CE setup and for the CE-inactive gap (4 us).
REQ-003 The block SHALL have a port named clk, input, 1 bit, 100 MHz system clock; the only clock.
REQ-004 The block SHALL have a port named rst, input, 1 bit, reset that is synchronous and active-low.
REQ-005 The block SHALL have a port named start, input, 1 bit, one-cycle request to write the time.
REQ-006 The block SHALL have ports secIn, minIn, hrsIn, dateIn, monIn, dayIn, yrIn, each input, 8 bits, BCD register images.
REQ-007 The block SHALL have a port named wpAfter, input, 1 bit, write-protect bit written in the burst control byte.
REQ-008 The block SHALL have a port named sclkOut, output, 1 bit, DS1302 SCLK.
REQ-009 The block SHALL have a port named ceOut, output, 1 bit, DS1302 CE.
REQ-010 The block SHALL have a port named dataOut, output, 1 bit, serial data to the I/O pin.
REQ-011 The block SHALL have a port named dataOe, output, 1 bit, pin drive enable; the top level muxes the pin with the reader.
REQ-012 The block SHALL have a port named busy, output, 1 bit, high while a write sequence is in progress.
REQ-013 The block SHALL have a port named done, output, 1 bit, one-cycle pulse when the sequence completes.

Function
REQ-014 When start is high in IDLE, the block SHALL capture all seven data inputs and wpAfter, and SHALL set busy high on the next cycle (T+1).
REQ-015 While busy, the block SHALL ignore start with no effect on the sequence or the captured data.
REQ-016 Transaction A: the block SHALL send command 0x8E, then data 0x00, to clear write-protect (16 bits).
REQ-017 Transaction B: the block SHALL send command 0xBE (clock burst write), then sec, min, hrs, date, mon, day, yr, then control {wpAfter,7'b0} (72 bits).
REQ-018 Bit order: the block SHALL shift every byte LSB first.
REQ-019 The state machine SHALL use states IDLE -> CE_SETUP -> SHIFT -> TAIL -> GAP -> CE_SETUP -> SHIFT -> TAIL -> IDLE, with a transaction flag selecting A or B.
REQ-020 CE_SETUP: ceOut SHALL be 1, sclkOut 0, and the state SHALL last CE_CYC cycles; dataOut SHALL already present bit 0 of the command.
REQ-021 SHIFT, per bit: the block SHALL hold sclkOut 0 for HALF_CYC cycles, then 1 for HALF_CYC cycles; dataOut SHALL change only on the cycle sclkOut goes 0, so data is stable at every rising edge.
REQ-022 TAIL: after the last bit's high phase, sclkOut SHALL be 0 and ceOut SHALL stay 1 for HALF_CYC cycles, then ceOut SHALL go 0.
REQ-023 GAP: ceOut, sclkOut and dataOe SHALL be 0 for CE_CYC cycles.
REQ-024 dataOe SHALL equal ceOut, since the DS1302 never drives during a write.
REQ-025 Latency: done SHALL pulse at cycle T+1+3*CE_CYC+178*HALF_CYC, and busy SHALL fall in that same cycle.
REQ-026 A start arriving in the same cycle as done SHALL be ignored; a new start is accepted from the following cycle.
REQ-027 The bit counter SHALL be 7 bits and the half-period counter SHALL be wide enough for max(HALF_CYC,CE_CYC)-1; both SHALL wrap to 0 at each phase end.

Reset
REQ-028 While rst==0 at a clk edge, the block SHALL enter IDLE.
REQ-029 While rst==0 at a clk edge, sclkOut, ceOut, dataOut, dataOe, busy and done SHALL all be 0.
REQ-030 While rst==0 at a clk edge, the counters and the shift register SHALL clear.
REQ-031 Reset mid-sequence SHALL abort immediately: CE SHALL drop in the same cycle and no done pulse SHALL occur.

Structure
REQ-032 Shared package ds1302_pkg SHALL hold the constants CMD_WP_WR=8'h8E, CMD_BURST_WR=8'hBE, CMD_BURST_RD=8'hBF and the state enum.
REQ-033 The ds1302_pkg constants SHALL be reused by ds1302read.
REQ-034 One sub-module SHALL be used: ds1302_bit_shifter (loads a byte, emits LSB-first bits on HALF_CYC phases, flags byte_done).
REQ-035 The FSM SHALL sequence bytes from a 9-entry byte mux.

Verification (HALF_CYC=2, CE_CYC=4)
REQ-036 Start with sec=0x45, min=0x30, hrs=0x12, date=0x15, mon=0x06, day=0x03, yr=0x24, wpAfter=1 -> the decoded bit stream SHALL be 8E 00 | BE 45 30 12 15 06 03 24 80.
REQ-037 In the same run, done SHALL pulse at T+369, busy SHALL be high for exactly 368 cycles, and exactly 88 rising SCLK edges SHALL occur.
REQ-038 Timing check: dataOut SHALL never toggle while sclkOut==1, and ceOut SHALL be low for exactly 4 cycles between transactions.
REQ-039 Start pulsed again at T+50 with different data -> the stream SHALL be unchanged and there SHALL be a single done.
REQ-040 rst=0 at T+120 (inside transaction B) -> all outputs SHALL be 0 next edge and no done; a new start SHALL then produce a full correct sequence.
REQ-041 wpAfter=0 -> the last byte SHALL be 0x00, with all other bytes and timing identical.

Source files
------------

// File: rtl/ds1302_pkg.sv
// ds1302_pkg -- shared definitions for the DS1302 serial RTC interface.
// Holds the command bytes used by both the writer (ds1302_write) and the
// reader (ds1302read), the per-transaction bit counts of the writer, and
// the writer's state enumeration.
package ds1302_pkg;

   // Command bytes (the address byte is always sent first, LSB first)
   localparam logic [7:0] CMD_WP_WR    = 8'h8E;  // write control register
   localparam logic [7:0] CMD_BURST_WR = 8'hBE;  // clock burst write
   localparam logic [7:0] CMD_BURST_RD = 8'hBF;  // clock burst read

   // Bits per write transaction: A = cmd + WP clear, B = cmd + 8 data bytes
   localparam logic [6:0] BITS_A = 7'd16;
   localparam logic [6:0] BITS_B = 7'd72;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CE_SETUP = 3'd1,
      SHIFT    = 3'd2,
      TAIL     = 3'd3,
      GAP      = 3'd4
   } ds1302_state_e;

endpackage

// File: rtl/ds1302_bit_shifter.sv
// ds1302_bit_shifter -- serialises one byte LSB first onto SCLK/data.
// Each bit is a low SCLK phase of HALF_CYC cycles followed by a high phase
// of HALF_CYC cycles. The data bit only changes in the cycle SCLK returns
// low, so it is stable around every rising SCLK edge.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset (clears shift register/counters)
//   load       load load_byte, restart at the low phase of bit 0
//   load_byte  byte to serialise
//   en         advance the phase timing (held low outside of shifting)
//   sclk       serial clock output
//   bit_out    current data bit (shift register bit 0)
//   bit_end    last cycle of a bit's high phase
//   byte_done  bit_end of the eighth bit
module ds1302_bit_shifter #(
   parameter int HALF_CYC = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_byte,
   input  logic       en,
   output logic       sclk,
   output logic       bit_out,
   output logic       bit_end,
   output logic       byte_done
);
   import ds1302_pkg::*;

   localparam int HW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYC - 1);

   logic [7:0]    sreg_q, sreg_d;
   logic [HW-1:0] half_q, half_d;
   logic          sclk_q, sclk_d;
   logic [2:0]    idx_q,  idx_d;

   // Derived from state only, never from load, so the parent may use these
   // flags to decide on a load in the same cycle without a loop.
   assign bit_end   = en & sclk_q & (half_q == HALF_LAST);
   assign byte_done = bit_end & (idx_q == 3'd7);

   always_comb begin
      sreg_d = sreg_q;
      half_d = half_q;
      sclk_d = sclk_q;
      idx_d  = idx_q;
      if (load) begin
         sreg_d = load_byte;
         half_d = '0;
         sclk_d = 1'b0;
         idx_d  = 3'd0;
      end else if (en) begin
         if (half_q == HALF_LAST) begin
            half_d = '0;
            sclk_d = ~sclk_q;
            // End of the high phase: move to the next bit as SCLK drops
            if (sclk_q) begin
               sreg_d = {1'b0, sreg_q[7:1]};
               idx_d  = idx_q + 3'd1;
            end
         end else begin
            half_d = half_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sreg_q <= '0;
         half_q <= '0;
         sclk_q <= 1'b0;
         idx_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         half_q <= half_d;
         sclk_q <= sclk_d;
         idx_q  <= idx_d;
      end
   end

   assign sclk    = sclk_q;
   assign bit_out = sreg_q[0];

endmodule

// File: rtl/ds1302_write.sv
// ds1302_write -- writes the time/date to a DS1302 RTC.
// On start it captures the seven BCD register images and wpAfter, then runs
// two CE-framed transactions: A clears write-protect (8E 00), B performs a
// clock burst write (BE sec min hrs date mon day yr {wpAfter,7'b0}).
//
// Ports:
//   clk                 100 MHz system clock
//   rst                 synchronous active-low reset
//   start               one-cycle write request (accepted in IDLE only)
//   secIn..yrIn         BCD register images
//   wpAfter             write-protect bit for the burst control byte
//   sclkOut, ceOut      DS1302 SCLK and CE
//   dataOut, dataOe     serial data and pin drive enable (equal to CE)
//   busy                high while a sequence runs
//   done                one-cycle pulse at the end of the sequence
module ds1302_write #(
   parameter int HALF_CYC = 100,
   parameter int CE_CYC   = 400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] secIn,
   input  logic [7:0] minIn,
   input  logic [7:0] hrsIn,
   input  logic [7:0] dateIn,
   input  logic [7:0] monIn,
   input  logic [7:0] dayIn,
   input  logic [7:0] yrIn,
   input  logic       wpAfter,
   output logic       sclkOut,
   output logic       ceOut,
   output logic       dataOut,
   output logic       dataOe,
   output logic       busy,
   output logic       done
);
   import ds1302_pkg::*;

   localparam int CNT_MAX = ((HALF_CYC > CE_CYC) ? HALF_CYC : CE_CYC) - 1;
   localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CE_LAST   = CNT_W'(CE_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

   ds1302_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       bit_cnt_q, bit_cnt_d;
   logic             txn_b_q, txn_b_d;
   logic             ce_q, ce_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       cap_q [7];
   logic [7:0]       cap_d [7];
   logic             wp_q, wp_d;

   logic             sh_load;
   logic [7:0]       sh_byte;
   logic             sh_en;
   logic             sh_sclk;
   logic             sh_bit;
   logic             sh_bit_end;
   logic             sh_byte_done;

   logic [3:0]       byte_idx;
   logic [7:0]       next_byte;
   logic [6:0]       last_bit;

   ds1302_bit_shifter #(.HALF_CYC(HALF_CYC)) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (sh_load),
      .load_byte (sh_byte),
      .en        (sh_en),
      .sclk      (sh_sclk),
      .bit_out   (sh_bit),
      .bit_end   (sh_bit_end),
      .byte_done (sh_byte_done)
   );

   // 9-entry byte mux: entry 0 is the command (loaded on CE_SETUP entry),
   // entries 1..8 follow it. Transaction A only has entry 1 = 0x00.
   assign byte_idx = bit_cnt_q[6:3] + 4'd1;
   assign last_bit = txn_b_q ? (BITS_B - 7'd1) : (BITS_A - 7'd1);

   always_comb begin
      next_byte = 8'h00;
      if (txn_b_q) begin
         case (byte_idx)
            4'd1:    next_byte = cap_q[0];
            4'd2:    next_byte = cap_q[1];
            4'd3:    next_byte = cap_q[2];
            4'd4:    next_byte = cap_q[3];
            4'd5:    next_byte = cap_q[4];
            4'd6:    next_byte = cap_q[5];
            4'd7:    next_byte = cap_q[6];
            4'd8:    next_byte = {wp_q, 7'b0};
            default: next_byte = 8'h00;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      txn_b_d   = txn_b_q;
      cap_d     = cap_q;
      wp_d      = wp_q;
      done_d    = 1'b0;
      sh_load   = 1'b0;
      sh_byte   = 8'h00;
      sh_en     = 1'b0;

      case (state_q)
         IDLE: begin
            // A start coinciding with the done pulse is dropped
            if (start && !done_q) begin
               cap_d[0]  = secIn;
               cap_d[1]  = minIn;
               cap_d[2]  = hrsIn;
               cap_d[3]  = dateIn;
               cap_d[4]  = monIn;
               cap_d[5]  = dayIn;
               cap_d[6]  = yrIn;
               wp_d      = wpAfter;
               txn_b_d   = 1'b0;
               cnt_d     = '0;
               bit_cnt_d = '0;
               sh_load   = 1'b1;
               sh_byte   = CMD_WP_WR;
               state_d   = CE_SETUP;
            end
         end
         CE_SETUP: begin
            if (cnt_q == CE_LAST) begin
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            sh_en = 1'b1;
            if (sh_bit_end) begin
               if (bit_cnt_q == last_bit) begin
                  bit_cnt_d = '0;
                  cnt_d     = '0;
                  state_d   = TAIL;
               end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
                  if (sh_byte_done) begin
                     sh_load = 1'b1;
                     sh_byte = next_byte;
                  end
               end
            end
         end
         TAIL: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (txn_b_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == CE_LAST) begin
               cnt_d   = '0;
               txn_b_d = 1'b1;
               sh_load = 1'b1;
               sh_byte = CMD_BURST_WR;
               state_d = CE_SETUP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // CE and busy are registered from the next state so they line up with
   // state_q and are glitch-free at the pins.
   assign ce_d   = (state_d == CE_SETUP) || (state_d == SHIFT) || (state_d == TAIL);
   assign busy_d = (state_d != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         txn_b_q   <= 1'b0;
         ce_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         txn_b_q   <= txn_b_d;
         ce_q      <= ce_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Captured register images need no reset; they are loaded on every start
   always_ff @(posedge clk) begin
      cap_q <= cap_d;
      wp_q  <= wp_d;
   end

   assign sclkOut = sh_sclk;
   assign ceOut   = ce_q;
   assign dataOe  = ce_q;
   assign dataOut = ce_q & sh_bit;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_ds1302_write.sv
// tb_ds1302_write -- directed bench for ds1302_write with HALF_CYC=2,
// CE_CYC=4. A negedge monitor decodes the bit stream at rising SCLK and
// tracks busy length, done pulses, the CE-low gap and data stability.
module tb_ds1302_write;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] secIn = 8'h00, minIn = 8'h00, hrsIn = 8'h00, dateIn = 8'h00;
   logic [7:0] monIn = 8'h00, dayIn = 8'h00, yrIn = 8'h00;
   logic       wpAfter = 1'b0;
   logic       sclkOut, ceOut, dataOut, dataOe, busy, done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_edge = 0;

   // monitor state
   logic mon_clr = 1'b0;
   int   n_rise = 0, n_busy = 0, n_done = 0, dat_bad = 0, oe_bad = 0;
   int   gap_len = -1, ce_run = 0;
   logic prev_sclk = 1'b0, prev_data = 1'b0;
   logic bit_buf [128];

   ds1302_write #(.HALF_CYC(2), .CE_CYC(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .secIn   (secIn),
      .minIn   (minIn),
      .hrsIn   (hrsIn),
      .dateIn  (dateIn),
      .monIn   (monIn),
      .dayIn   (dayIn),
      .yrIn    (yrIn),
      .wpAfter (wpAfter),
      .sclkOut (sclkOut),
      .ceOut   (ceOut),
      .dataOut (dataOut),
      .dataOe  (dataOe),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_clr) begin
         n_rise = 0; n_busy = 0; n_done = 0; dat_bad = 0; oe_bad = 0;
         gap_len = -1; ce_run = 0; prev_sclk = 1'b0; prev_data = 1'b0;
      end else begin
         if (sclkOut && !prev_sclk) begin
            if (n_rise < 128) bit_buf[n_rise] = dataOut;
            n_rise++;
         end
         if (sclkOut && (dataOut !== prev_data)) dat_bad++;
         if (dataOe !== ceOut) oe_bad++;
         if (busy) n_busy++;
         if (done) n_done++;
         if (busy && !ceOut) ce_run++;
         else if (ce_run > 0) begin
            gap_len = ce_run;
            ce_run = 0;
         end
         prev_sclk = sclkOut;
         prev_data = dataOut;
      end
   end

   // Drive one start pulse; returns #1 after the edge that samples it.
   // Inputs are then scrambled to show the DUT works from its captured copy.
   task automatic start_write(input logic [7:0] s, mi, h, dt, mo, dy, y,
                              input logic wp);
      @(posedge clk); #1;
      secIn = s; minIn = mi; hrsIn = h; dateIn = dt;
      monIn = mo; dayIn = dy; yrIn = y; wpAfter = wp;
      start = 1'b1; mon_clr = 1'b1;
      @(posedge clk); #1;
      start_edge = cyc;
      start = 1'b0; mon_clr = 1'b0;
      secIn = 8'hFF; minIn = 8'hFF; hrsIn = 8'hFF; dateIn = 8'hFF;
      monIn = 8'hFF; dayIn = 8'hFF; yrIn = 8'hFF; wpAfter = ~wp;
   endtask

   // Bounded wait for done; lat = edges from the start-sampling edge.
   task automatic wait_done(output bit ok, output int lat);
      ok = 1'b0;
      lat = -1;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(posedge clk); #1;
         if (done) begin
            ok = 1'b1;
            lat = cyc - start_edge;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({sclkOut, ceOut, dataOut, dataOe, busy, done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {sclkOut, ceOut, dataOut, dataOe, busy, done});
      end
      rst = 1'b1;
   endtask

   task automatic test_basic;
      logic [7:0] exp [11];
      logic [7:0] b;
      bit ok;
      int lat;
      exp = '{8'h8E, 8'h00, 8'hBE, 8'h45, 8'h30, 8'h12, 8'h15, 8'h06,
              8'h03, 8'h24, 8'h80};
      start_write(8'h45, 8'h30, 8'h12, 8'h15, 8'h06, 8'h03, 8'h24, 1'b1);
      // cycle T+1: CE set up, SCLK low, bit 0 of 0x8E (=0) already out
      checks++;
      if ({busy, ceOut, sclkOut, dataOut, dataOe} !== 5'b11001) begin
         errors++;
         $display("FAIL basic_t1: busy,ce,sclk,data,oe got %b expected 11001",
                  {busy, ceOut, sclkOut, dataOut, dataOe});
      end
      wait_done(ok, lat);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_done_seen: got none expected one within 600 cycles");
      end
      // done in cycle T+369 == 368 edges after the sampling edge
      checks++;
      if (lat != 368) begin
         errors++;
         $display("FAIL basic_latency: got %0d expected 368", lat);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_at_done: got %b expected 0", busy);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (n_busy != 368) begin
         errors++;
         $display("FAIL basic_busy_len: got %0d expected 368", n_busy);
      end
      checks++;
      if (n_rise != 88) begin
         errors++;
         $display("FAIL basic_sclk_rises: got %0d expected 88", n_rise);
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL basic_done_count: got %0d expected 1", n_done);
      end
      checks++;
      if (gap_len != 4) begin
         errors++;
         $display("FAIL basic_ce_gap: got %0d expected 4", gap_len);
      end
      checks++;
      if (dat_bad != 0) begin
         errors++;
         $display("FAIL basic_data_stable: got %0d toggles expected 0", dat_bad);
      end
      checks++;
      if (oe_bad != 0) begin
         errors++;
         $display("FAIL basic_oe_eq_ce: got %0d mismatches expected 0", oe_bad);
      end
      for (int j = 0; j < 11; j++) begin
         for (int k = 0; k < 8; k++) b[k] = bit_buf[j*8+k];
         checks++;
         if (b !== exp[j]) begin
            errors++;
            $display("FAIL basic_byte%0d: got %02h expected %02h", j, b, exp[j]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp [11];
      logic [7:0] b;
      bit ok;
      int lat;
      exp = '{8'h8E, 8'h00, 8'hBE, 8'h45, 8'h30, 8'h12, 8'h15, 8'h06,
              8'h03, 8'h24, 8'h80};
      start_write(8'h45, 8'h30, 8'h12, 8'h15, 8'h06, 8'h03, 8'h24, 1'b1);
      // second start in cycle T+50 with different data
      repeat (49) @(posedge clk);
      #1;
      secIn = 8'h11; minIn = 8'h22; hrsIn = 8'h33; dateIn = 8'h44;
      monIn = 8'h05; dayIn = 8'h06; yrIn = 8'h77; wpAfter = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(ok, lat);
      checks++;
      if (lat != 368) begin
         errors++;
         $display("FAIL b2b_latency: got %0d expected 368", lat);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d expected 1", n_done);
      end
      checks++;
      if (n_rise != 88) begin
         errors++;
         $display("FAIL b2b_sclk_rises: got %0d expected 88", n_rise);
      end
      for (int j = 0; j < 11; j++) begin
         for (int k = 0; k < 8; k++) b[k] = bit_buf[j*8+k];
         checks++;
         if (b !== exp[j]) begin
            errors++;
            $display("FAIL b2b_byte%0d: got %02h expected %02h", j, b, exp[j]);
         end
      end
   endtask

   task automatic test_wp_clear;
      logic [7:0] exp [11];
      logic [7:0] b;
      bit ok;
      int lat;
      exp = '{8'h8E, 8'h00, 8'hBE, 8'h59, 8'h59, 8'h23, 8'h31, 8'h12,
              8'h07, 8'h99, 8'h00};
      start_write(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99, 1'b0);
      wait_done(ok, lat);
      checks++;
      if (lat != 368) begin
         errors++;
         $display("FAIL wp0_latency: got %0d expected 368", lat);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (gap_len != 4 || n_rise != 88 || dat_bad != 0) begin
         errors++;
         $display("FAIL wp0_timing: gap=%0d rises=%0d toggles=%0d expected 4 88 0",
                  gap_len, n_rise, dat_bad);
      end
      for (int j = 0; j < 11; j++) begin
         for (int k = 0; k < 8; k++) b[k] = bit_buf[j*8+k];
         checks++;
         if (b !== exp[j]) begin
            errors++;
            $display("FAIL wp0_byte%0d: got %02h expected %02h", j, b, exp[j]);
         end
      end
   endtask

   task automatic test_start_at_done;
      bit ok;
      int lat;
      start_write(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 1'b1);
      wait_done(ok, lat);
      // still inside the done cycle: this start must be dropped
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL done_cycle_start_ignored: busy got %b expected 0", busy);
      end
      start_write(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 1'b1);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL start_after_done: busy got %b expected 1", busy);
      end
      wait_done(ok, lat);
      checks++;
      if (lat != 368) begin
         errors++;
         $display("FAIL start_after_done_latency: got %0d expected 368", lat);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] exp [11];
      logic [7:0] b;
      bit ok;
      int lat;
      exp = '{8'h8E, 8'h00, 8'hBE, 8'h45, 8'h30, 8'h12, 8'h15, 8'h06,
              8'h03, 8'h24, 8'h80};
      start_write(8'h45, 8'h30, 8'h12, 8'h15, 8'h06, 8'h03, 8'h24, 1'b1);
      repeat (118) @(posedge clk);
      #1;
      checks++;
      if (ceOut !== 1'b1) begin
         errors++;
         $display("FAIL mid_in_txn_b: ce got %b expected 1", ceOut);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({sclkOut, ceOut, dataOut, dataOe, busy, done} !== 6'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b expected 000000",
                  {sclkOut, ceOut, dataOut, dataOe, busy, done});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      checks++;
      if (n_done != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_done: dones=%0d busy=%b expected 0 0", n_done, busy);
      end
      start_write(8'h45, 8'h30, 8'h12, 8'h15, 8'h06, 8'h03, 8'h24, 1'b1);
      wait_done(ok, lat);
      checks++;
      if (lat != 368) begin
         errors++;
         $display("FAIL mid_restart_latency: got %0d expected 368", lat);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < 11; j++) begin
         for (int k = 0; k < 8; k++) b[k] = bit_buf[j*8+k];
         checks++;
         if (b !== exp[j]) begin
            errors++;
            $display("FAIL mid_restart_byte%0d: got %02h expected %02h", j, b, exp[j]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_wp_clear();
      test_start_at_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
